// File: rtl/ccff_chain_loader.sv
// Serializes parallel configuration words MSB-first onto the head of the
// configuration flip-flop chain, issuing exactly CHAIN_LEN shift enables per load.
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_word_data,
    input  logic              cfg_word_valid,
    output logic              cfg_word_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_loaded
);

    localparam int                IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  LEN      = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state, w_state_next;
    logic [WORD_W-1:0] r_shift, w_shift_next;
    logic [IDX_W-1:0]  r_bit_idx, w_bit_idx_next;
    logic [CNT_W-1:0]  r_bits_loaded, w_bits_loaded_next;
    logic              r_head, w_head_next;
    logic              r_pce, w_pce_next;

    logic              w_ready;
    logic              w_xfer;
    logic              w_last_of_word;
    logic              w_last_of_chain;
    logic [CNT_W-1:0]  w_bits_inc;
    logic [WORD_W-1:0] w_shifted;

    assign w_bits_inc      = r_bits_loaded + 1'b1;
    assign w_last_of_word  = (r_bit_idx == LAST_IDX);
    assign w_last_of_chain = (w_bits_inc == LEN);
    assign w_shifted       = r_shift << 1;
    assign w_xfer          = w_ready && cfg_word_valid;

    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_bit_idx_next     = r_bit_idx;
        w_bits_loaded_next = r_bits_loaded;
        w_head_next        = r_head;
        w_pce_next         = 1'b0;
        w_ready            = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next       = S_WAIT_WORD;
                    w_bits_loaded_next = '0;
                end
            end
            S_WAIT_WORD: begin
                w_ready = 1'b1;
            end
            S_SHIFT: begin
                // The bit on ccff_head is clocked into the chain at the end of this cycle.
                w_bits_loaded_next = w_bits_inc;
                if (w_last_of_chain) begin
                    w_state_next = S_DONE;
                end else if (w_last_of_word) begin
                    w_ready      = 1'b1;
                    w_state_next = S_WAIT_WORD;
                end else begin
                    w_shift_next   = w_shifted;
                    w_head_next    = w_shifted[WORD_W-1];
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    w_pce_next     = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A word accepted here starts shifting next cycle, back-to-back with the previous one.
        if (w_xfer) begin
            w_state_next   = S_SHIFT;
            w_shift_next   = cfg_word_data;
            w_head_next    = cfg_word_data[WORD_W-1];
            w_bit_idx_next = '0;
            w_pce_next     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_idx     <= '0;
            r_bits_loaded <= '0;
            r_head        <= 1'b0;
            r_pce         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_bit_idx     <= w_bit_idx_next;
            r_bits_loaded <= w_bits_loaded_next;
            r_head        <= w_head_next;
            r_pce         <= w_pce_next;
        end
    end

    assign cfg_word_ready = w_ready;
    assign ccff_head      = r_head;
    assign prog_clk_en    = r_pce;
    assign busy           = (r_state == S_WAIT_WORD) || (r_state == S_SHIFT);
    assign done           = (r_state == S_DONE);
    assign bits_loaded    = r_bits_loaded;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader: two instances (CHAIN_LEN 20 and 16)
// checked every cycle against a stream-level model of accepted words.
module tb_ccff_chain_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start = 1'b0;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit directed = 1'b0;
    int vmode = 0;

    logic [1:0]  rdy_o, head_o, pce_o, busy_o, done_o;
    logic [15:0] bl_o [2];
    logic [W-1:0] tbl [3] = '{8'hA5, 8'h3C, 8'hF0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input int w);
        if (directed && w < 3) return tbl[w];
        return W'($urandom);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int CL = (gi == 0) ? 20 : 16;

        logic [W-1:0] data  = '0;
        logic         valid = 1'b0;
        bit           active = 1'b0;
        int           pcnt = 0;
        int           xfers = 0;
        bit           q[$];
        bit           took = 1'b0;
        bit           restart = 1'b0;
        int           wcnt = 0;
        int           gap = 0;

        ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL), .CNT_W(16)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start),
            .cfg_word_data  (data),
            .cfg_word_valid (valid),
            .cfg_word_ready (rdy_o[gi]),
            .ccff_head      (head_o[gi]),
            .prog_clk_en    (pce_o[gi]),
            .busy           (busy_o[gi]),
            .done           (done_o[gi]),
            .bits_loaded    (bl_o[gi])
        );

        // Model: the chain must receive the accepted words MSB-first, truncated to CL bits.
        always @(negedge clk) begin : model
            int rem;
            bit e_pce, e_rdy, e_busy, e_done;
            if (mon_en) begin
                rem    = q.size() - pcnt;
                e_busy = active && (pcnt < CL);
                e_done = active && (pcnt == CL);
                e_pce  = e_busy && (rem > 0);
                e_rdy  = e_busy && (rem <= 1) && (pcnt + rem < CL);
                check($sformatf("i%0d busy", gi),  32'(busy_o[gi]), 32'(e_busy));
                check($sformatf("i%0d done", gi),  32'(done_o[gi]), 32'(e_done));
                check($sformatf("i%0d pce", gi),   32'(pce_o[gi]),  32'(e_pce));
                check($sformatf("i%0d ready", gi), 32'(rdy_o[gi]),  32'(e_rdy));
                check($sformatf("i%0d bits_loaded", gi), 32'(bl_o[gi]), 32'(pcnt));
                if (e_pce)
                    check($sformatf("i%0d head bit%0d", gi, pcnt), 32'(head_o[gi]), 32'(q[pcnt]));
                if (reset) begin
                    active = 1'b0; q.delete(); pcnt = 0; xfers = 0; restart = 1'b1;
                end else begin
                    if (valid && rdy_o[gi]) took = 1'b1;
                    if (e_pce) begin
                        pcnt++;
                        if (pcnt == CL)
                            check($sformatf("i%0d words taken", gi), 32'(xfers), 32'((CL + W - 1) / W));
                    end
                    if (valid && e_rdy) begin
                        for (int b = W - 1; b >= 0; b--) q.push_back(data[b]);
                        xfers++;
                    end
                    if (start && !e_busy) begin
                        active = 1'b1; q.delete(); pcnt = 0; xfers = 0; restart = 1'b1;
                    end
                end
            end
        end

        // Source: holds each word until accepted; vmode 0 = always valid, 1 = random, 2 = 5-cycle gap.
        always @(posedge clk) begin : source
            #1;
            if (restart) begin
                wcnt = 0; data = pick(0); gap = 0;
            end else if (took) begin
                wcnt++; data = pick(wcnt); gap = (vmode == 2) ? 5 : 0;
            end
            restart = 1'b0;
            took    = 1'b0;
            if (gap > 0) begin
                valid = 1'b0; gap--;
            end else if (vmode == 1) begin
                valid = ($urandom_range(9) < 7);
            end else begin
                valid = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_o != 2'b11 && n < 2000) begin
            tick();
            n++;
        end
        check("load done", 32'(done_o), 32'(2'b11));
    endtask

    task automatic wait_bits(input int nb);
        int n;
        n = 0;
        while (bl_o[0] < 16'(nb) && n < 500) begin
            tick();
            n++;
        end
        check("bits reached", 32'(bl_o[0] >= 16'(nb)), 32'(1));
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst i%0d head", i),  32'(head_o[i]), 32'(0));
            check($sformatf("rst i%0d pce", i),   32'(pce_o[i]),  32'(0));
            check($sformatf("rst i%0d ready", i), 32'(rdy_o[i]),  32'(0));
            check($sformatf("rst i%0d busy", i),  32'(busy_o[i]), 32'(0));
            check($sformatf("rst i%0d done", i),  32'(done_o[i]), 32'(0));
            check($sformatf("rst i%0d bits", i),  32'(bl_o[i]),   32'(0));
        end
    endtask

    initial begin
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_state();
        $display("idle: 50 cycles with valid high");
        repeat (50) tick();

        directed = 1'b1;
        vmode = 0;
        pulse_start();
        wait_done();
        $display("load A5 3C F0 streaming: bits_loaded=%0d/%0d", bl_o[0], bl_o[1]);

        vmode = 2;
        pulse_start();
        wait_done();
        $display("load A5 3C F0 with gaps: bits_loaded=%0d/%0d", bl_o[0], bl_o[1]);

        vmode = 0;
        pulse_start();
        wait_bits(10);
        pulse_start();
        wait_done();
        check("start-while-busy bits", 32'(bl_o[0]), 32'(20));
        $display("load with ignored start: bits_loaded=%0d", bl_o[0]);

        pulse_start();
        wait_bits(12);
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        pulse_start();
        wait_done();
        check("post-reset reload bits", 32'(bl_o[0]), 32'(20));
        $display("abort at bit 12 then reload: bits_loaded=%0d", bl_o[0]);

        directed = 1'b0;
        vmode = 1;
        for (int k = 0; k < 15; k++) begin
            pulse_start();
            if ($urandom_range(2) == 0) begin
                repeat ($urandom_range(12)) tick();
                pulse_start();
            end
            wait_done();
            $display("random load %0d: bits_loaded=%0d/%0d", k, bl_o[0], bl_o[1]);
            repeat ($urandom_range(3)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Bitstream writer for the configuration-chain flip-flop string.
- Accepts parallel configuration words over a valid/ready handshake and serializes them MSB-first onto the chain head, with a per-bit shift enable.
- Stops after exactly CHAIN_LEN bits, then reports done.
- Sits between the bitstream source (SPI/JTAG/boot ROM interface) and the head of the fabric's configuration chain.

Parameters:
- WORD_W, 32, width of each input configuration word.
- CHAIN_LEN, 1024, total number of configuration bits in the chain; must be >= 1.
- CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- cfg_word_data  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- cfg_word_valid  input  1  source has a word on cfg_word_data.
- cfg_word_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial data into the chain head (registered).
- prog_clk_en  output  1  chain shifts ccff_head in at the end of every cycle where this is 1 (registered).
- busy  output  1  high in WAIT_WORD and SHIFT.
- done  output  1  high in DONE.
- bits_loaded  output  CNT_W  number of bits shifted since the last start.

Behaviour:
- Reset values: state=IDLE, cfg_word_ready=0, ccff_head=0, prog_clk_en=0, busy=0, done=0, bits_loaded=0, shift register=0.
- Reset asserted mid-load aborts immediately. The chain is left partially loaded; no further prog_clk_en pulses occur.
- Word handshake: a transfer occurs on an edge where cfg_word_valid && cfg_word_ready. Data must be stable while valid is high. The source may hold valid with no time limit.
- State IDLE:
  - outputs quiet.
  - start -> WAIT_WORD; bits_loaded cleared to 0.
- State WAIT_WORD:
  - cfg_word_ready=1, prog_clk_en=0.
  - On transfer: load word into shift register, drive ccff_head=word[WORD_W-1] and prog_clk_en=1 in the following cycle, set bit index=0, -> SHIFT.
  - No valid: remain; no shift pulses.
- State SHIFT, one bit per cycle:
  - prog_clk_en=1; bits_loaded increments by 1 per bit shifted.
  - Shift register shifts left; ccff_head carries the next MSB.
  - Last bit of the current word with bits_loaded+1 < CHAIN_LEN: cfg_word_ready=1.
    - Transfer on that edge: next word loads and its MSB follows with no bubble; stay in SHIFT.
    - No transfer: -> WAIT_WORD, and prog_clk_en=0 next cycle.
  - Bit that makes bits_loaded == CHAIN_LEN: -> DONE; prog_clk_en=0 next cycle. Any remaining low bits of the current word are discarded (partial last word).
  - cfg_word_ready=0 on every other SHIFT cycle.
- State DONE:
  - done=1, busy=0, bits_loaded holds CHAIN_LEN, cfg_word_ready=0.
  - start -> WAIT_WORD with bits_loaded cleared (reload).
- start while busy: ignored; no effect on state or counters.
- Throughput and latency:
  - Sustained rate is 1 bit/clk when valid is kept high.
  - Latency from the first transfer edge to the first prog_clk_en cycle is 1 cycle.
  - Full load takes CHAIN_LEN cycles plus stall cycles.
- Total prog_clk_en pulses per load: exactly CHAIN_LEN, never more, regardless of how many words the source offers.
- Counter: bits_loaded never exceeds CHAIN_LEN and does not wrap.

Test Plan (WORD_W=8, CHAIN_LEN=20 unless noted):
- Reset then idle -> all outputs 0; no prog_clk_en for 50 cycles with valid=1.
- start, then words 0xA5, 0x3C, 0xF0 with valid held high:
  - serial stream is 10100101 00111100 1111 (20 bits), with prog_clk_en high for 20 consecutive cycles.
  - cfg_word_ready pulses exactly 3 times.
  - done rises the cycle after the last bit; bits_loaded=20.
- Same load with valid dropped for 5 cycles between words -> prog_clk_en low for 5+ cycles at each gap; stream content identical; total pulses=20.
- start during SHIFT after 10 bits -> ignored; load completes normally with bits_loaded=20.
- reset asserted after bit 12 -> next cycle all outputs are reset values. start + new load completes 20 bits from bits_loaded=0.
- CHAIN_LEN=16, WORD_W=8: two words 0xFF, 0x00 -> 16 pulses, no third ready. In DONE, start reloads and requests a word again.
